// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the pipelined data memory.
package dmem_pkg;

  // Controller state: CLEAR zeroes the array, RUN serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_RD_LAT = 1;

  // Word-address width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// RD_LAT-deep shift register carrying read valid, data and error.
// Data and error are forced to zero whenever the matching valid is low,
// so the outputs read as zero on every idle cycle.
module dmem_resp_pipe #(
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] e_q;
  logic [W-1:0]      d_q [RD_LAT];

  // Shift one stage per cycle; reset flushes every in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      e_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      e_q[0] <= in_valid & in_err;
      d_q[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[RD_LAT-1];
  assign out_err   = e_q[RD_LAT-1];
  assign out_data  = d_q[RD_LAT-1];

endmodule

// File: rtl/dmem_pipelined.sv
// Single-port data memory with byte-enable writes, a fixed read latency
// and a power-up/reset clear sequence that zeroes every word.
//
// Request handshake: a request transfers on a rising edge where
// req_valid and req_ready are both 1. req_ready is high only in RUN.
// Writes produce no response; every accepted read produces exactly one
// resp_valid pulse RD_LAT cycles after its accept edge, in order.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int RD_LAT = DEF_RD_LAT,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done,
  output state_t            dbg_state
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("dmem_pipelined: DATA_W must be a non-zero multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("dmem_pipelined: RD_LAT must be in 1..3");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data;

  // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
  assign addr_ok = ({1'b0, req_addr} < DEPTH_EXT);
  assign wr_fire = req_valid & req_ready & req_we;
  assign rd_fire = req_valid & req_ready & ~req_we;
  assign rd_data = addr_ok ? mem[req_addr] : '0;

  // Clear/run controller with registered ready and init_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state     <= CLEAR;
          clr_cnt   <= '0;
          req_ready <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage: clear writes zeros, run applies byte-enabled in-range writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_fire && addr_ok) begin
        for (int b = 0; b < BE_W; b++) begin
          if (req_be[b]) begin
            mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign dbg_state = state;

  dmem_resp_pipe #(
    .W      (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_resp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .in_err    (~addr_ok),
    .out_valid (resp_valid),
    .out_data  (resp_rdata),
    .out_err   (resp_err)
  );

endmodule
